car_motion_fsm: RTL and testbench



---
 rtl/car_motion_fsm.sv | 159 +++++++++++++++
 tb/tb_car_motion_fsm.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_motion_fsm.sv
// Carriage motion and door sequencer: times floor-to-floor travel and door dwell, reports floor and arrival pulse.
// Latency: IDLE->MOVE 1 cycle, TRAVEL_CYCLES per floor, CHECK+DOOR 2 cycles after a floor change; no backpressure.
module car_motion_fsm #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  should_move,
    input  logic                  direction,
    input  logic [NUM_FLOORS-1:0] call_inside,
    input  logic [NUM_FLOORS-1:0] call_up,
    input  logic [NUM_FLOORS-1:0] call_down,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  floor_reached,
    output logic                  door_open,
    output logic                  moving,
    output logic                  motor_dir,
    output logic [1:0]            state_out
);

    localparam int TRAV_W = $clog2(TRAVEL_CYCLES);
    localparam int DOOR_W = $clog2(DOOR_CYCLES);
    localparam logic [TRAV_W-1:0]  TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        CHECK = 2'd2,
        DOOR  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [FLOOR_W-1:0]  floor_nxt;
    logic                dir_nxt;
    logic [TRAV_W-1:0]   travel_cnt, travel_nxt;
    logic [DOOR_W-1:0]   door_cnt, door_nxt;
    logic                reached_nxt;
    logic [2:0]          prev_calls;

    logic [NUM_FLOORS-1:0] any_call;
    logic [2:0]            cur_calls;
    logic                  here;
    logic                  beyond_up;
    logic                  beyond_dn;
    logic                  at_top;
    logic                  at_bot;
    logic                  stop_here;
    logic                  call_rise;
    logic                  can_depart;

    assign any_call  = call_inside | call_up | call_down;
    assign cur_calls = {call_inside[cur_floor], call_up[cur_floor], call_down[cur_floor]};
    assign here      = |cur_calls;
    assign at_top    = (cur_floor == TOP_FLOOR);
    assign at_bot    = (cur_floor == '0);
    // A new call at the current floor while the door is open extends the dwell.
    assign call_rise = |(cur_calls & ~prev_calls);

    always_comb begin
        beyond_up = 1'b0;
        beyond_dn = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (any_call[i] && (i > int'(cur_floor))) beyond_up = 1'b1;
            if (any_call[i] && (i < int'(cur_floor))) beyond_dn = 1'b1;
        end
    end

    assign can_depart = should_move && !(direction && at_top) && !(!direction && at_bot);

    assign stop_here = call_inside[cur_floor]
                     | ( motor_dir & call_up[cur_floor])
                     | (~motor_dir & call_down[cur_floor])
                     | ( motor_dir & (~beyond_up | at_top))
                     | (~motor_dir & (~beyond_dn | at_bot));

    always_comb begin
        state_nxt  = state;
        floor_nxt  = cur_floor;
        dir_nxt    = motor_dir;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;
        case (state)
            IDLE: begin
                if (here) begin
                    state_nxt = DOOR;
                    door_nxt  = '0;
                end else if (can_depart) begin
                    state_nxt  = MOVE;
                    dir_nxt    = direction;
                    travel_nxt = '0;
                end
            end
            MOVE: begin
                if (travel_cnt == TRAV_LAST) begin
                    travel_nxt = '0;
                    floor_nxt  = motor_dir ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
                    state_nxt  = CHECK;
                end else begin
                    travel_nxt = travel_cnt + TRAV_W'(1);
                end
            end
            CHECK: begin
                if (stop_here) begin
                    if (here) begin
                        state_nxt = DOOR;
                        door_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = MOVE;
                end
            end
            DOOR: begin
                if (call_rise) begin
                    door_nxt = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    door_nxt  = '0;
                    state_nxt = IDLE;
                end else begin
                    door_nxt = door_cnt + DOOR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Pulse only on entry into DOOR, never on a dwell restart.
        reached_nxt = (state_nxt == DOOR) && (state != DOOR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cur_floor     <= '0;
            motor_dir     <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            floor_reached <= 1'b0;
            prev_calls    <= '0;
        end else begin
            state         <= state_nxt;
            cur_floor     <= floor_nxt;
            motor_dir     <= dir_nxt;
            travel_cnt    <= travel_nxt;
            door_cnt      <= door_nxt;
            floor_reached <= reached_nxt;
            prev_calls    <= cur_calls;
        end
    end

    assign door_open = (state == DOOR);
    assign moving    = (state == MOVE) || (state == CHECK);
    assign state_out = state;

endmodule

// File: tb/tb_car_motion_fsm.sv
// Scoreboarded bench: trips are planned as event timelines; a negedge monitor matches observed events.
module tb_car_motion_fsm;
    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TR = 4;
    localparam int DR = 3;

    localparam int EV_DEPART = 0;
    localparam int EV_FLOOR  = 1;
    localparam int EV_PULSE  = 2;
    localparam int EV_HALT   = 3;
    localparam int EV_CLOSE  = 4;

    typedef struct {
        int kind;
        int cyc;
        int floor;
        int dir;
        int st;
    } ev_t;

    logic          clk;
    logic          reset;
    logic          should_move;
    logic          direction;
    logic [NF-1:0] call_inside;
    logic [NF-1:0] call_up;
    logic [NF-1:0] call_down;
    logic [FW-1:0] cur_floor;
    logic          floor_reached;
    logic          door_open;
    logic          moving;
    logic          motor_dir;
    logic [1:0]    state_out;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    int  mfloor = 0;
    bit  mon_en = 0;
    ev_t exp_q[$];

    car_motion_fsm #(
        .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TR), .DOOR_CYCLES(DR)
    ) dut (
        .clk(clk), .reset(reset), .should_move(should_move), .direction(direction),
        .call_inside(call_inside), .call_up(call_up), .call_down(call_down),
        .cur_floor(cur_floor), .floor_reached(floor_reached), .door_open(door_open),
        .moving(moving), .motor_dir(motor_dir), .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input int f, input int d, input int s);
        ev_t e;
        e.kind = k; e.cyc = c; e.floor = f; e.dir = d; e.st = s;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input int f, input int d, input int s);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d cyc=%0d floor=%0d dir=%0d st=%0d required none",
                     k, cyc, f, d, s);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.floor != f || e.dir != d || e.st != s) begin
                errors++;
                $display("FAIL event actual kind=%0d cyc=%0d floor=%0d dir=%0d st=%0d required kind=%0d cyc=%0d floor=%0d dir=%0d st=%0d",
                         k, cyc, f, d, s, e.kind, e.cyc, e.floor, e.dir, e.st);
            end
        end
    endtask

    // Monitor: turns output edges into events and matches them against the plan.
    initial begin
        int  p_floor;
        bit  p_mov, p_door;
        p_floor = 0; p_mov = 0; p_door = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (moving && !p_mov)
                    observe(EV_DEPART, int'(cur_floor), int'(motor_dir), int'(state_out));
                if (int'(cur_floor) != p_floor)
                    observe(EV_FLOOR, int'(cur_floor), int'(motor_dir), int'(state_out));
                if (floor_reached)
                    observe(EV_PULSE, int'(cur_floor), 0, int'(state_out));
                if (!moving && p_mov)
                    observe(EV_HALT, int'(cur_floor), 0, int'(state_out));
                if (!door_open && p_door)
                    observe(EV_CLOSE, int'(cur_floor), 0, int'(state_out));
            end
            p_floor = int'(cur_floor);
            p_mov   = moving;
            p_door  = door_open;
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_calls();
        call_inside = '0; call_up = '0; call_down = '0;
    endtask

    // One trip from the model floor: plan the event timeline, then drive it.
    // rr>0 raises an in-car call at the stop floor during door cycle rr+1.
    task automatic trip(input int dir, input logic [NF-1:0] ci, input logic [NF-1:0] cu,
                        input logic [NF-1:0] cd, input int rr);
        int s, k, pos, t, tf, h, endt;
        bit blocked, stop, beyond, door;
        logic [NF-1:0] anyc;
        s    = mfloor;
        k    = cyc;
        anyc = ci | cu | cd;
        blocked = (dir == 1 && s == NF - 1) || (dir == 0 && s == 0);
        pos = s; tf = k; h = k; endt = k + 4; door = 0;
        if (!blocked) begin
            t = k + 1;
            push(EV_DEPART, t, s, dir, 1);
            for (int n = 0; n < NF; n++) begin
                tf  = t + TR;
                pos = (dir == 1) ? pos + 1 : pos - 1;
                push(EV_FLOOR, tf, pos, dir, 2);
                beyond = 0;
                for (int i = 0; i < NF; i++)
                    if (anyc[i] && ((dir == 1) ? (i > pos) : (i < pos))) beyond = 1;
                stop = ci[pos] || ((dir == 1) ? cu[pos] : cd[pos]) || !beyond ||
                       pos == ((dir == 1) ? NF - 1 : 0);
                if (stop) break;
                t = tf + 1;
            end
            h    = tf + 1;
            door = anyc[pos];
            if (door) begin
                push(EV_PULSE, h, pos, 0, 3);
                push(EV_HALT, h, pos, 0, 3);
                endt = h + DR + ((rr > 0) ? rr + 1 : 0);
                push(EV_CLOSE, endt, pos, 0, 0);
            end else begin
                push(EV_HALT, h, pos, 0, 0);
                endt = h;
            end
        end
        call_inside = ci; call_up = cu; call_down = cd;
        should_move = 1'b1;
        direction   = dir[0];
        @(posedge clk); #1;
        should_move = 1'b0;
        if (blocked) begin
            clear_calls();
        end else begin
            wait_until(h);
            clear_calls();
            if (door && rr > 0) begin
                wait_until(h + rr);
                call_inside[pos] = 1'b1;
                wait_until(h + rr + 1);
                call_inside = '0;
            end
        end
        wait_until(endt + 2);
        mfloor = pos;
    endtask

    initial begin
        logic [NF-1:0] ci, cu, cd;
        int dir, rr;
        reset = 1'b0; should_move = 1'b0; direction = 1'b0;
        clear_calls();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(state_out), 0);
        chk("reset_floor", int'(cur_floor), 0);
        chk("reset_motor_dir", int'(motor_dir), 1);
        chk("reset_moving", int'(moving), 0);
        chk("reset_door", int'(door_open), 0);
        reset  = 1'b1;
        mon_en = 1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_state", int'(state_out), 0);
        chk("idle_floor", int'(cur_floor), 0);
        chk("idle_door", int'(door_open), 0);

        trip(1, NF'(8'h08), '0, '0, 0);
        trip(1, NF'(8'h80), '0, '0, 0);
        trip(1, '0, '0, '0, 0);
        chk("top_guard_floor", int'(cur_floor), 7);
        chk("top_guard_moving", int'(moving), 0);
        chk("top_guard_state", int'(state_out), 0);
        trip(0, NF'(8'h04), '0, '0, 0);
        trip(1, NF'(8'h40), '0, NF'(8'h10), 0);
        chk("pass4_stop6_floor", int'(cur_floor), 6);
        chk("pass4_stop6_state", int'(state_out), 0);
        trip(0, NF'(8'h20), '0, '0, 1);

        for (int n = 0; n < 24; n++) begin
            ci = NF'($urandom) & NF'($urandom);
            cu = NF'($urandom) & NF'($urandom);
            cd = NF'($urandom) & NF'($urandom);
            ci &= ~(NF'(1) << mfloor);
            cu &= ~(NF'(1) << mfloor);
            cd &= ~(NF'(1) << mfloor);
            dir = int'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DR - 1)) : 0;
            trip(dir, ci, cu, cd, rr);
        end
        chk("random_end_floor", int'(cur_floor), mfloor);

        if (mfloor != 2) trip((mfloor > 2) ? 0 : 1, NF'(8'h04), '0, '0, 0);
        mon_en = 0;
        call_inside = NF'(8'h40);
        should_move = 1'b1;
        direction   = 1'b1;
        @(posedge clk); #1;
        should_move = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("premid_moving", int'(moving), 1);
        reset = 1'b0;
        #1;
        chk("midreset_state", int'(state_out), 0);
        chk("midreset_floor", int'(cur_floor), 0);
        chk("midreset_moving", int'(moving), 0);
        chk("midreset_door", int'(door_open), 0);
        chk("midreset_pulse", int'(floor_reached), 0);
        chk("midreset_motor_dir", int'(motor_dir), 1);
        clear_calls();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        mfloor = 0;
        mon_en = 1;
        @(posedge clk); #1;
        trip(1, NF'(8'h02), '0, '0, 0);
        chk("after_reset_floor", int'(cur_floor), 1);

        chk("pending_events", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
